int_controller: RTL and testbench



---
 rtl/intc_pkg.sv | 32 +++
 rtl/intc_prio_enc.sv | 31 +++
 rtl/int_controller.sv | 218 +++++++++++++++++++++
 tb/tb_int_controller.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// ----------------------------------------------------------------------------
// intc_pkg
// Shared definitions for the interrupt controller:
//   - state_t  : controller FSM states
//   - VEC_W    : width of the handler vector address
//   - MAX_IRQ  : largest supported number of maskable lines
//   - ID_W     : width of a maskable source index (covers MAX_IRQ)
//   - vec_addr : base + id * stride, truncated to VEC_W bits
// ----------------------------------------------------------------------------
package intc_pkg;

  localparam int VEC_W   = 32;
  localparam int MAX_IRQ = 8;
  localparam int ID_W    = $clog2(MAX_IRQ);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    SVC     = 3'd2,
    NMI_REQ = 3'd3,
    NMI_SVC = 3'd4
  } state_t;

  function automatic logic [VEC_W-1:0] vec_addr(
    input logic [VEC_W-1:0] base,
    input logic [VEC_W-1:0] stride,
    input logic [ID_W-1:0]  id
  );
    return base + stride * {{(VEC_W-ID_W){1'b0}}, id};
  endfunction

endpackage

// File: rtl/intc_prio_enc.sv
// ----------------------------------------------------------------------------
// intc_prio_enc
// Combinational priority encoder. Index 0 has the highest priority.
// Ports:
//   eligible  in  N     request vector
//   valid     out 1     at least one bit of eligible is set
//   idx       out ID_W  index of the lowest set bit (0 when none)
// ----------------------------------------------------------------------------
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    eligible,
  output logic            valid,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    // Walk from the top down so the lowest set index is the last writer.
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        idx   = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_controller.sv
// ----------------------------------------------------------------------------
// int_controller
// Latches rising edges on maskable IRQ lines and an NMI line, picks the
// highest-priority source, requests service from the CPU controller with a
// handler vector, and tracks in-service state until end-of-interrupt. One
// level of NMI nesting over a maskable handler is supported.
//
// Optional build macro: INTC_SYNC_EN -- when defined, irq/nmi pass through a
// 2-flop synchronizer before edge detection (two extra cycles of latency).
//
// Ports:
//   clk          in  1        rising-edge clock
//   rst_n        in  1        asynchronous active-low reset
//   irq          in  NUM_IRQ  maskable sources, edge-triggered
//   nmi          in  1        non-maskable source, edge-triggered
//   int_disable  in  1        global maskable disable (NMI unaffected)
//   mask_we      in  1        enable-mask write strobe
//   mask_wdata   in  NUM_IRQ  new enable mask (1 = enabled)
//   mask         out NUM_IRQ  current enable mask
//   pending      out NUM_IRQ  latched maskable pending bits
//   irq_req      out 1        request to CPU controller
//   irq_is_nmi   out 1        current request/service is NMI
//   irq_vector   out 32       handler address, stable while irq_req=1
//   irq_ack      in  1        one-cycle acknowledge
//   eoi          in  1        one-cycle end-of-interrupt
//   in_service   out 1        a handler is executing
// ----------------------------------------------------------------------------
module int_controller
  import intc_pkg::*;
#(
  parameter int               NUM_IRQ    = 4,
  parameter logic [VEC_W-1:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [VEC_W-1:0] VEC_STRIDE = 32'h0000_0010,
  parameter logic [VEC_W-1:0] NMI_VEC    = 32'h0000_0080
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi,
  input  logic               int_disable,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] mask,
  output logic [NUM_IRQ-1:0] pending,
  output logic               irq_req,
  output logic               irq_is_nmi,
  output logic [VEC_W-1:0]   irq_vector,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               in_service
);

  // Bit NUM_IRQ of the sample vectors carries the NMI line.
  logic [NUM_IRQ:0] in_src;
  logic [NUM_IRQ:0] samp_reg;
  logic [NUM_IRQ:0] prev_reg;
  logic [NUM_IRQ:0] rise;

`ifdef INTC_SYNC_EN
  logic [NUM_IRQ:0] sync1_reg;
  logic [NUM_IRQ:0] sync2_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= {nmi, irq};
      sync2_reg <= sync1_reg;
    end
  end

  assign in_src = sync2_reg;
`else
  assign in_src = {nmi, irq};
`endif

  // Samples reset to 0, so a line already high at reset exit is an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_reg <= '0;
      prev_reg <= '0;
    end else begin
      samp_reg <= in_src;
      prev_reg <= samp_reg;
    end
  end

  assign rise = samp_reg & ~prev_reg;

  // --------------------------------------------------------------------------
  // Control state
  // --------------------------------------------------------------------------
  state_t             state_reg, state_next;
  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [NUM_IRQ-1:0] mask_reg;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr_bits;
  logic               nmi_pend_reg, nmi_pend_next, nmi_clr;
  logic               nested_reg, nested_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic [ID_W-1:0]    enc_idx;
  logic               enc_valid;
  logic [VEC_W-1:0]   vector_reg, vector_next;
  logic               req_reg, req_next;
  logic               is_nmi_reg, is_nmi_next;
  logic               svc_reg, svc_next;

  assign eligible = pending_reg & mask_reg & {NUM_IRQ{~int_disable}};

  intc_prio_enc #(
    .N (NUM_IRQ)
  ) u_prio_enc (
    .eligible (eligible),
    .valid    (enc_valid),
    .idx      (enc_idx)
  );

  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    vector_next = vector_reg;
    nested_next = nested_reg;
    clr_bits    = '0;
    nmi_clr     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (nmi_pend_reg) begin
          state_next  = NMI_REQ;
          vector_next = NMI_VEC;
        end else if (enc_valid) begin
          state_next  = REQ;
          id_next     = enc_idx;
          vector_next = vec_addr(VEC_BASE, VEC_STRIDE, enc_idx);
        end
      end
      REQ: begin
        if (irq_ack) begin
          state_next = SVC;
          for (int i = 0; i < NUM_IRQ; i++) begin
            clr_bits[i] = (id_reg == ID_W'(i));
          end
        end else if (int_disable || nmi_pend_reg) begin
          // Withdraw; the pending bit stays set for a later retry.
          state_next = IDLE;
        end
      end
      SVC: begin
        if (eoi) begin
          state_next = IDLE;
        end else if (nmi_pend_reg) begin
          state_next  = NMI_REQ;
          nested_next = 1'b1;
          vector_next = NMI_VEC;
        end
      end
      NMI_REQ: begin
        if (irq_ack) begin
          state_next = NMI_SVC;
          nmi_clr    = 1'b1;
        end
      end
      NMI_SVC: begin
        if (eoi) begin
          state_next  = nested_reg ? SVC : IDLE;
          nested_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase

    // A new edge in the clearing cycle wins over the clear.
    pending_next  = (pending_reg & ~clr_bits) | rise[NUM_IRQ-1:0];
    nmi_pend_next = (nmi_pend_reg & ~nmi_clr) | rise[NUM_IRQ];

    // Outputs are registered copies decoded from the next state.
    req_next    = (state_next == REQ)     || (state_next == NMI_REQ);
    is_nmi_next = (state_next == NMI_REQ) || (state_next == NMI_SVC);
    svc_next    = (state_next == SVC)     || (state_next == NMI_SVC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      nmi_pend_reg <= 1'b0;
      nested_reg   <= 1'b0;
      mask_reg     <= '0;
      id_reg       <= '0;
      vector_reg   <= '0;
      req_reg      <= 1'b0;
      is_nmi_reg   <= 1'b0;
      svc_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      nmi_pend_reg <= nmi_pend_next;
      nested_reg   <= nested_next;
      id_reg       <= id_next;
      vector_reg   <= vector_next;
      req_reg      <= req_next;
      is_nmi_reg   <= is_nmi_next;
      svc_reg      <= svc_next;
      if (mask_we) begin
        mask_reg <= mask_wdata;
      end
    end
  end

  assign mask       = mask_reg;
  assign pending    = pending_reg;
  assign irq_req    = req_reg;
  assign irq_is_nmi = is_nmi_reg;
  assign irq_vector = vector_reg;
  assign in_service = svc_reg;

endmodule

// File: tb/tb_int_controller.sv
// ----------------------------------------------------------------------------
// tb_int_controller
// Self-checking bench for int_controller (default build, 4 IRQ lines).
// Expected requests are queued when the stimulus is driven and compared when
// the controller raises irq_req.
// ----------------------------------------------------------------------------
module tb_int_controller;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  irq;
  logic          nmi;
  logic          int_disable;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic [N-1:0]  mask;
  logic [N-1:0]  pending;
  logic          irq_req;
  logic          irq_is_nmi;
  logic [31:0]   irq_vector;
  logic          irq_ack;
  logic          eoi;
  logic          in_service;

  typedef struct packed {
    logic [31:0] vec;
    logic        nmi;
  } txn_t;

  txn_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int_controller #(
    .NUM_IRQ    (N),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0010),
    .NMI_VEC    (32'h0000_0080)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq         (irq),
    .nmi         (nmi),
    .int_disable (int_disable),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .mask        (mask),
    .pending     (pending),
    .irq_req     (irq_req),
    .irq_is_nmi  (irq_is_nmi),
    .irq_vector  (irq_vector),
    .irq_ack     (irq_ack),
    .eoi         (eoi),
    .in_service  (in_service)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] v, input logic is_nmi);
    txn_t t;
    t.vec = v;
    t.nmi = is_nmi;
    exp_q.push_back(t);
  endtask

  // Wait (bounded) for a request, compare it with the scoreboard head,
  // and optionally acknowledge it.
  task automatic take_request(input bit do_ack);
    txn_t e;
    int   k;
    k = 0;
    while (irq_req !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (irq_req !== 1'b1) begin
      n_bad++;
      $display("FAIL req_timeout: irq_req=%b after %0d cycles, required 1", irq_req, k);
      return;
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_req: vector=%h with empty scoreboard, required no request", irq_vector);
      return;
    end
    e = exp_q.pop_front();
    $display("txn: vector=%h nmi=%b expected vector=%h nmi=%b",
             irq_vector, irq_is_nmi, e.vec, e.nmi);
    n_cmp++;
    if (irq_vector !== e.vec) begin
      n_bad++;
      $display("FAIL req_vector: got %h, required %h", irq_vector, e.vec);
    end
    n_cmp++;
    if (irq_is_nmi !== e.nmi) begin
      n_bad++;
      $display("FAIL req_is_nmi: got %b, required %b", irq_is_nmi, e.nmi);
    end
    if (do_ack) begin
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      n_cmp++;
      if (irq_req !== 1'b0) begin
        n_bad++;
        $display("FAIL ack_req_drop: irq_req=%b, required 0", irq_req);
      end
      n_cmp++;
      if (in_service !== 1'b1) begin
        n_bad++;
        $display("FAIL ack_in_service: in_service=%b, required 1", in_service);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; irq = '0; nmi = 1'b0; int_disable = 1'b0;
    mask_we = 1'b0; mask_wdata = '0; irq_ack = 1'b0; eoi = 1'b0;
    idle_cycles(3);
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if ({irq_req, irq_is_nmi, in_service} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_ctl: req/nmi/svc=%b, required 000", {irq_req, irq_is_nmi, in_service});
    end
    n_cmp++;
    if (irq_vector !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_vector: got %h, required 00000000", irq_vector);
    end
    n_cmp++;
    if ({mask, pending} !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_mask_pend: mask=%b pending=%b, required 0000/0000", mask, pending);
    end
  endtask

  task automatic test_single();
    write_mask(4'b1111);
    irq = 4'b0100;
    push_exp(32'h120, 1'b0);
    tick();
    tick();
    n_cmp++;
    if (pending !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_pending: got %b, required 0100", pending);
    end
    n_cmp++;
    if (irq_req !== 1'b0) begin
      n_bad++;
      $display("FAIL single_early_req: irq_req=%b, required 0", irq_req);
    end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1) begin
      n_bad++;
      $display("FAIL single_latency: irq_req=%b, required 1", irq_req);
    end
    take_request(1'b1);
    n_cmp++;
    if (pending !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_pend_clear: got %b, required 0000", pending);
    end
    pulse_eoi();
    n_cmp++;
    if (in_service !== 1'b0) begin
      n_bad++;
      $display("FAIL single_eoi: in_service=%b, required 0", in_service);
    end
    irq = '0;
    idle_cycles(3);
  endtask

  task automatic test_priority();
    irq = 4'b1010;
    push_exp(32'h110, 1'b0);
    push_exp(32'h130, 1'b0);
    take_request(1'b1);
    pulse_eoi();
    n_cmp++;
    if (irq_req !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_eoi_gap: irq_req=%b, required 0", irq_req);
    end
    tick();
    n_cmp++;
    if (irq_req !== 1'b1) begin
      n_bad++;
      $display("FAIL prio_second_req: irq_req=%b, required 1", irq_req);
    end
    take_request(1'b1);
    pulse_eoi();
    irq = '0;
    idle_cycles(3);
  endtask

  task automatic test_mask();
    write_mask(4'b0000);
    irq = 4'b0001;
    idle_cycles(4);
    n_cmp++;
    if (pending !== 4'b0001) begin
      n_bad++;
      $display("FAIL mask_pending: got %b, required 0001", pending);
    end
    n_cmp++;
    if (irq_req !== 1'b0) begin
      n_bad++;
      $display("FAIL mask_blocked: irq_req=%b, required 0", irq_req);
    end
    push_exp(32'h100, 1'b0);
    write_mask(4'b0001);
    take_request(1'b1);
    pulse_eoi();
    irq = '0;
    write_mask(4'b1111);
    idle_cycles(2);
  endtask

  task automatic test_disable();
    irq = 4'b0010;
    push_exp(32'h110, 1'b0);
    take_request(1'b0);
    int_disable = 1'b1;
    tick();
    n_cmp++;
    if (irq_req !== 1'b0) begin
      n_bad++;
      $display("FAIL disable_withdraw: irq_req=%b, required 0", irq_req);
    end
    idle_cycles(2);
    n_cmp++;
    if (pending !== 4'b0010 || irq_req !== 1'b0) begin
      n_bad++;
      $display("FAIL disable_hold: pending=%b irq_req=%b, required 0010/0", pending, irq_req);
    end
    int_disable = 1'b0;
    push_exp(32'h110, 1'b0);
    take_request(1'b1);
    pulse_eoi();
    irq = '0;
    idle_cycles(3);
  endtask

  task automatic test_nmi_nested();
    irq = 4'b0100;
    push_exp(32'h120, 1'b0);
    take_request(1'b1);
    nmi = 1'b1;
    push_exp(32'h80, 1'b1);
    take_request(1'b1);
    n_cmp++;
    if (irq_is_nmi !== 1'b1) begin
      n_bad++;
      $display("FAIL nmi_svc_flag: irq_is_nmi=%b, required 1", irq_is_nmi);
    end
    pulse_eoi();
    n_cmp++;
    if ({in_service, irq_is_nmi, irq_req} !== 3'b100) begin
      n_bad++;
      $display("FAIL nmi_back_to_svc: svc/nmi/req=%b, required 100", {in_service, irq_is_nmi, irq_req});
    end
    pulse_eoi();
    n_cmp++;
    if ({in_service, irq_req} !== 2'b00) begin
      n_bad++;
      $display("FAIL nmi_final_eoi: svc/req=%b, required 00", {in_service, irq_req});
    end
    irq = '0;
    nmi = 1'b0;
    idle_cycles(3);
  endtask

  task automatic test_reset_in_nmi_svc();
    nmi = 1'b1;
    irq = 4'b0011;
    push_exp(32'h80, 1'b1);
    take_request(1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({irq_req, irq_is_nmi, in_service} !== 3'b000 || irq_vector !== 32'h0) begin
      n_bad++;
      $display("FAIL async_reset: req/nmi/svc=%b vector=%h, required 000/00000000",
               {irq_req, irq_is_nmi, in_service}, irq_vector);
    end
    n_cmp++;
    if ({mask, pending} !== 8'h00) begin
      n_bad++;
      $display("FAIL async_reset_regs: mask=%b pending=%b, required 0000/0000", mask, pending);
    end
    idle_cycles(2);
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (pending !== 4'b0011) begin
      n_bad++;
      $display("FAIL fresh_edges: pending=%b, required 0011", pending);
    end
    // NMI is still held high, so it is a fresh edge too.
    push_exp(32'h80, 1'b1);
    take_request(1'b1);
    pulse_eoi();
    push_exp(32'h100, 1'b0);
    push_exp(32'h110, 1'b0);
    write_mask(4'b0011);
    take_request(1'b1);
    pulse_eoi();
    take_request(1'b1);
    pulse_eoi();
    irq = '0;
    nmi = 1'b0;
    idle_cycles(3);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask();
    test_disable();
    test_nmi_nested();
    test_reset_in_nmi_svc();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
